// File: rtl/trigger_timestamp.sv
// Two-event trigger timestamper.
// Event A (trigger0 falling) and event B (trigger1 rising) are stamped against a
// free-running counter. The block reports the A->B delta and opens an
// acquisition gate of programmable length starting at event A.
module trigger_timestamp #(
    parameter int                    TS_WIDTH   = 32,
    parameter int                    GATE_WIDTH = 24,
    parameter logic [GATE_WIDTH-1:0] TIMEOUT    = GATE_WIDTH'(24'hFFFFFF)
) (
    input  logic                  adc_clk,
    input  logic                  trig_reset,
    input  logic                  arm,
    input  logic [GATE_WIDTH-1:0] acq_len,
    input  logic                  trigger0,
    input  logic                  trigger1,
    output logic                  acq_gate,
    output logic [TS_WIDTH-1:0]   ts_a,
    output logic [TS_WIDTH-1:0]   ts_b,
    output logic [TS_WIDTH-1:0]   delta_ab,
    output logic                  ts_valid,
    output logic                  timeout,
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_WAIT_B = 3'd2;
    localparam logic [2:0] S_ACQ    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q,    state_d;
    logic [TS_WIDTH-1:0]   ts_cnt_q,   ts_cnt_d;
    logic                  t0_q,       t0_d;
    logic                  t1_q,       t1_d;
    logic [GATE_WIDTH-1:0] len_q,      len_d;
    logic [GATE_WIDTH-1:0] gate_cnt_q, gate_cnt_d;
    logic [GATE_WIDTH-1:0] to_cnt_q,   to_cnt_d;
    logic                  acq_gate_q, acq_gate_d;
    logic [TS_WIDTH-1:0]   ts_a_q,     ts_a_d;
    logic [TS_WIDTH-1:0]   ts_b_q,     ts_b_d;
    logic [TS_WIDTH-1:0]   delta_q,    delta_d;
    logic                  valid_q,    valid_d;
    logic                  timeout_q,  timeout_d;
    logic                  busy_q,     busy_d;

    logic fall_a;
    logic rise_b;

    // Edge detection against the previous-cycle copies of the trigger inputs.
    assign fall_a = t0_q & ~trigger0;
    assign rise_b = ~t1_q & trigger1;

    // State and datapath registers; reset discards any capture in flight.
    always_ff @(posedge adc_clk or posedge trig_reset) begin
        if (trig_reset) begin
            state_q    <= S_IDLE;
            ts_cnt_q   <= '0;
            t0_q       <= 1'b0;
            t1_q       <= 1'b0;
            len_q      <= '0;
            gate_cnt_q <= '0;
            to_cnt_q   <= '0;
            acq_gate_q <= 1'b0;
            ts_a_q     <= '0;
            ts_b_q     <= '0;
            delta_q    <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_cnt_q   <= ts_cnt_d;
            t0_q       <= t0_d;
            t1_q       <= t1_d;
            len_q      <= len_d;
            gate_cnt_q <= gate_cnt_d;
            to_cnt_q   <= to_cnt_d;
            acq_gate_q <= acq_gate_d;
            ts_a_q     <= ts_a_d;
            ts_b_q     <= ts_b_d;
            delta_q    <= delta_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; B wins over timeout in the same cycle, illegal codes recover to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (fall_a) state_d = rise_b ? S_ACQ : S_WAIT_B;
            end
            S_WAIT_B: begin
                if (rise_b)                 state_d = S_ACQ;
                else if (to_cnt_q == TIMEOUT) state_d = S_DONE;
            end
            S_ACQ: begin
                if (gate_cnt_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters, captures and registered outputs.
    always_comb begin
        ts_cnt_d   = ts_cnt_q + 1'b1;
        t0_d       = trigger0;
        t1_d       = trigger1;
        len_d      = len_q;
        gate_cnt_d = gate_cnt_q;
        to_cnt_d   = to_cnt_q;
        acq_gate_d = acq_gate_q;
        ts_a_d     = ts_a_q;
        ts_b_d     = ts_b_q;
        delta_d    = delta_q;
        valid_d    = valid_q;
        timeout_d  = timeout_q;

        // The gate runs independently of B: it closes on the 1 -> 0 count step.
        if (acq_gate_q) begin
            gate_cnt_d = gate_cnt_q - 1'b1;
            if (gate_cnt_q == GATE_WIDTH'(1)) acq_gate_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    // A zero length would give no gate at all; treat it as one cycle.
                    len_d     = (acq_len == '0) ? GATE_WIDTH'(1) : acq_len;
                    valid_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_ARMED: begin
                if (fall_a) begin
                    ts_a_d     = ts_cnt_q;
                    gate_cnt_d = len_q;
                    acq_gate_d = 1'b1;
                    to_cnt_d   = '0;
                    if (rise_b) begin
                        ts_b_d  = ts_cnt_q;
                        delta_d = '0;
                    end
                end
            end
            S_WAIT_B: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (rise_b) begin
                    ts_b_d  = ts_cnt_q;
                    delta_d = ts_cnt_q - ts_a_q;
                end else if (to_cnt_q == TIMEOUT) begin
                    timeout_d  = 1'b1;
                    acq_gate_d = 1'b0;
                    gate_cnt_d = '0;
                end
            end
            S_ACQ: begin
                if (gate_cnt_q == '0) valid_d = 1'b1;
            end
            default: ;
        endcase

        busy_d = (state_d == S_ARMED) || (state_d == S_WAIT_B) || (state_d == S_ACQ);
    end

    assign acq_gate = acq_gate_q;
    assign ts_a     = ts_a_q;
    assign ts_b     = ts_b_q;
    assign delta_ab = delta_q;
    assign ts_valid = valid_q;
    assign timeout  = timeout_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_trigger_timestamp.sv
// Bench for trigger_timestamp: directed and randomized capture scenarios.
// Two instances share the triggers: one with the default timeout, one with a
// short timeout. Each is armed separately so only the selected one is active.
module tb_trigger_timestamp;

    localparam int TSW  = 10;
    localparam int GW   = 24;
    localparam int TO_T = 16;
    localparam int TO_M = 24'hFFFFFF;
    localparam int TMOD = 1 << TSW;

    logic            adc_clk = 1'b0;
    logic            trig_reset;
    logic            arm_m, arm_t;
    logic [GW-1:0]   acq_len;
    logic            trigger0, trigger1;

    logic            gate_m, valid_m, to_m, busy_m;
    logic [TSW-1:0]  tsa_m, tsb_m, dlt_m;
    logic            gate_t, valid_t, to_t, busy_t;
    logic [TSW-1:0]  tsa_t, tsb_t, dlt_t;

    logic            o_gate, o_valid, o_to, o_busy;
    logic [TSW-1:0]  o_tsa, o_tsb, o_dlt;

    int  compared   = 0;
    int  mismatched = 0;
    int  tcnt;
    bit  sel = 1'b0;

    trigger_timestamp #(.TS_WIDTH(TSW), .GATE_WIDTH(GW)) dut_m (
        .adc_clk(adc_clk), .trig_reset(trig_reset), .arm(arm_m), .acq_len(acq_len),
        .trigger0(trigger0), .trigger1(trigger1), .acq_gate(gate_m), .ts_a(tsa_m),
        .ts_b(tsb_m), .delta_ab(dlt_m), .ts_valid(valid_m), .timeout(to_m), .busy(busy_m)
    );

    trigger_timestamp #(.TS_WIDTH(TSW), .GATE_WIDTH(GW), .TIMEOUT(24'd16)) dut_t (
        .adc_clk(adc_clk), .trig_reset(trig_reset), .arm(arm_t), .acq_len(acq_len),
        .trigger0(trigger0), .trigger1(trigger1), .acq_gate(gate_t), .ts_a(tsa_t),
        .ts_b(tsb_t), .delta_ab(dlt_t), .ts_valid(valid_t), .timeout(to_t), .busy(busy_t)
    );

    always #5 adc_clk = ~adc_clk;

    // Reference time base: cycles elapsed since reset, modulo the counter range.
    always @(posedge adc_clk or posedge trig_reset) begin
        if (trig_reset) tcnt <= 0;
        else            tcnt <= (tcnt + 1) % TMOD;
    end

    always_comb begin
        o_gate  = sel ? gate_t  : gate_m;
        o_valid = sel ? valid_t : valid_m;
        o_to    = sel ? to_t    : to_m;
        o_busy  = sel ? busy_t  : busy_m;
        o_tsa   = sel ? tsa_t   : tsa_m;
        o_tsb   = sel ? tsb_t   : tsb_m;
        o_dlt   = sel ? dlt_t   : dlt_m;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic arm_pulse(input logic [GW-1:0] len);
        acq_len = len;
        if (sel) arm_t = 1'b1; else arm_m = 1'b1;
        step();
        arm_m = 1'b0;
        arm_t = 1'b0;
    endtask

    // One capture. Cycle k counts from the event-A cycle (k=0); values checked
    // at k are those registered at the end of cycle k-1.
    task automatic scn(input string tag, input bit s, input int len_in, input int target_a,
                       input int d_a, input bit has_b, input int d_b, input bit pre_b);
        int leff, tmo, k_done, k_end, exp_a, exp_b, guard;
        sel      = s;
        trigger0 = 1'b1;
        trigger1 = 1'b0;
        step();
        step();
        arm_pulse(len_in[GW-1:0]);
        chk({tag, " busy_after_arm"}, 32'(o_busy), 32'd1);
        chk({tag, " valid_after_arm"}, 32'(o_valid), 32'd0);
        chk({tag, " timeout_after_arm"}, 32'(o_to), 32'd0);
        leff   = (len_in == 0) ? 1 : len_in;
        tmo    = s ? TO_T : TO_M;
        exp_b  = 0;
        if (pre_b) begin
            trigger1 = 1'b1;
            step();
            trigger1 = 1'b0;
            step();
            chk({tag, " busy_after_early_b"}, 32'(o_busy), 32'd1);
            chk({tag, " gate_after_early_b"}, 32'(o_gate), 32'd0);
        end
        if (target_a >= 0) begin
            guard = 0;
            while (tcnt != target_a && guard < 4 * TMOD) begin
                step();
                guard++;
            end
            compared++;
            if (guard >= 4 * TMOD) begin
                mismatched++;
                $error("FAIL %s wait_for_target: observed %0d expected %0d", tag, tcnt, target_a);
            end
        end else begin
            for (int i = 0; i < d_a; i++) begin
                step();
                chk($sformatf("%s gate_before_a i=%0d", tag, i), 32'(o_gate), 32'd0);
            end
        end
        exp_a    = tcnt;
        trigger0 = 1'b0;
        if (has_b && d_b == 0) begin
            trigger1 = 1'b1;
            exp_b    = tcnt;
        end
        if (has_b) k_done = ((d_b > leff) ? d_b : leff) + 2;
        else       k_done = tmo + 2;
        k_end = k_done + 3;
        for (int k = 1; k <= k_end; k++) begin
            step();
            chk($sformatf("%s gate k=%0d", tag, k), 32'(o_gate),
                32'((k <= leff) && (has_b || k < tmo + 2)));
            chk($sformatf("%s valid k=%0d", tag, k), 32'(o_valid), 32'(has_b && k >= k_done));
            chk($sformatf("%s timeout k=%0d", tag, k), 32'(o_to), 32'(!has_b && k >= k_done));
            chk($sformatf("%s busy k=%0d", tag, k), 32'(o_busy), 32'(k < k_done));
            if (has_b && k == d_b) begin
                trigger1 = 1'b1;
                exp_b    = tcnt;
            end
            if (has_b && k == d_b + 2) trigger1 = 1'b0;
            if (k == 2) trigger0 = 1'b1;
            if (k == 3) trigger0 = 1'b0;
            if (k == 4) trigger0 = 1'b1;
            if (k == 1 || k == 2) begin
                acq_len = 24'd3;
                if (s) arm_t = 1'b1; else arm_m = 1'b1;
            end else begin
                arm_m = 1'b0;
                arm_t = 1'b0;
            end
        end
        trigger0 = 1'b1;
        trigger1 = 1'b0;
        chk({tag, " ts_a"}, 32'(o_tsa), 32'(exp_a));
        if (has_b) begin
            chk({tag, " ts_b"}, 32'(o_tsb), 32'(exp_b));
            chk({tag, " delta_ab"}, 32'(o_dlt), 32'((exp_b - exp_a + TMOD) % TMOD));
        end
        $display("scenario %s: sel=%0d len=%0d ts_a=%0d has_b=%0d ts_b=%0d delta=%0d valid=%0d timeout=%0d",
                 tag, s, len_in, o_tsa, has_b, o_tsb, o_dlt, o_valid, o_to);
    endtask

    initial begin
        bit rs, rb, rp;
        int rl, rda, rdb;
        trig_reset = 1'b1;
        arm_m      = 1'b0;
        arm_t      = 1'b0;
        acq_len    = '0;
        trigger0   = 1'b1;
        trigger1   = 1'b0;
        #22;
        chk("reset gate_m", 32'(gate_m), 32'd0);
        chk("reset busy_m", 32'(busy_m), 32'd0);
        chk("reset valid_m", 32'(valid_m), 32'd0);
        chk("reset timeout_m", 32'(to_m), 32'd0);
        chk("reset ts_a_m", 32'(tsa_m), 32'd0);
        chk("reset delta_t", 32'(dlt_t), 32'd0);
        trig_reset = 1'b0;

        // Basic capture, B well after the gate has closed.
        scn("basic", 1'b0, 10, 100, 0, 1'b1, 30, 1'b0);
        // Zero length, A and B in the same cycle.
        scn("same_cycle", 1'b0, 0, 50, 0, 1'b1, 0, 1'b0);
        // Short timeout, early B ignored, gate longer than the timeout window.
        scn("timeout", 1'b1, 20, -1, 2, 1'b0, 0, 1'b1);
        // Re-arm after timeout clears it and a normal capture completes.
        scn("rearm_after_to", 1'b1, 5, -1, 1, 1'b1, 7, 1'b1);
        // Counter wrap between A and B.
        scn("wrap", 1'b0, 4, TMOD - 5, 0, 1'b1, 8, 1'b0);
        // Arm straight out of DONE.
        scn("arm_in_done", 1'b0, 6, -1, 0, 1'b1, 3, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rs  = 1'($urandom_range(0, 1));
            rb  = rs ? 1'($urandom_range(0, 1)) : 1'b1;
            rp  = 1'($urandom_range(0, 1));
            rl  = int'($urandom_range(0, 25));
            rda = int'($urandom_range(0, 4));
            rdb = int'($urandom_range(0, rs ? TO_T : 40));
            scn($sformatf("rand%0d", n), rs, rl, -1, rda, rb, rdb, rp);
        end

        // Asynchronous reset while waiting for B with the gate open.
        sel      = 1'b0;
        trigger0 = 1'b1;
        step();
        step();
        arm_pulse(24'd8);
        trigger0 = 1'b0;
        step();
        chk("rst_mid precond gate", 32'(gate_m), 32'd1);
        chk("rst_mid precond busy", 32'(busy_m), 32'd1);
        #2;
        trig_reset = 1'b1;
        #1;
        chk("rst_mid gate", 32'(gate_m), 32'd0);
        chk("rst_mid busy", 32'(busy_m), 32'd0);
        chk("rst_mid ts_a", 32'(tsa_m), 32'd0);
        #2;
        trig_reset = 1'b0;
        trigger0   = 1'b1;
        step();
        chk("after_rst busy", 32'(busy_m), 32'd0);
        chk("after_rst valid", 32'(valid_m), 32'd0);
        chk("after_rst gate", 32'(gate_m), 32'd0);
        arm_pulse(24'd5);
        chk("after_rst arm busy", 32'(busy_m), 32'd1);
        $display("reset mid-capture: busy=%0d gate=%0d", busy_m, gate_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
